// File: rtl/seq_step_counter_pkg.sv
// ---------------------------------------------------------------------------
// seq_ctrl_pkg
// Shared definitions for the multiplier step-sequencing logic.
//   state_e           : FSM state encoding (IDLE / RUN / DONE, 2 bits)
//   DIR_UP / DIR_DN   : values of up_dn
//   MODE_WRAP/MODE_SAT: values of sat
// ---------------------------------------------------------------------------
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/seq_step_counter_if.sv
// ---------------------------------------------------------------------------
// seq_step_counter_if
// Control/status bundle between the multiplier controller (master) and the
// step counter (slave).
//   master drives : sclr, start, en, up_dn, sat, load, load_val
//   slave drives  : count_out, tc, wrap_pulse, busy, done
// ---------------------------------------------------------------------------
interface seq_step_counter_if #(
    parameter int WIDTH = 2
);
    logic             sclr;
    logic             start;
    logic             en;
    logic             up_dn;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count_out;
    logic             tc;
    logic             wrap_pulse;
    logic             busy;
    logic             done;

    modport master (
        output sclr, start, en, up_dn, sat, load, load_val,
        input  count_out, tc, wrap_pulse, busy, done
    );

    modport slave (
        input  sclr, start, en, up_dn, sat, load, load_val,
        output count_out, tc, wrap_pulse, busy, done
    );
endinterface

// File: rtl/seq_step_counter_next.sv
// ---------------------------------------------------------------------------
// seq_step_next
// Purely combinational next-count logic for the step counter.
//   i_count    : current count
//   i_load_val : raw parallel-load value
//   i_up_dn    : direction (free mode)
//   i_sat      : saturate/wrap mode (free mode)
//   o_cnt_free : next count for an enabled free-mode step
//   o_wrap     : that free-mode step wraps
//   o_cnt_run  : next count in RUN (returns to 0 after MODULUS-1)
//   o_cnt_load : load value clamped to MODULUS-1
//   o_at_max   : count == MODULUS-1
//   o_at_min   : count == 0
// ---------------------------------------------------------------------------
module seq_step_next
    import seq_ctrl_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int MODULUS = 4
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_up_dn,
    input  logic             i_sat,
    output logic [WIDTH-1:0] o_cnt_free,
    output logic             o_wrap,
    output logic [WIDTH-1:0] o_cnt_run,
    output logic [WIDTH-1:0] o_cnt_load,
    output logic             o_at_max,
    output logic             o_at_min
);
    // Compares are done one bit wider so MODULUS == 2^WIDTH is representable
    // and the end-of-range hit never depends on natural overflow.
    localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] LAST  = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] w_inc;
    logic [WIDTH:0] w_lv_ext;
    logic           w_at_max;
    logic           w_at_min;

    assign w_inc    = {1'b0, i_count} + (WIDTH+1)'(1);
    assign w_lv_ext = {1'b0, i_load_val};
    assign w_at_max = (w_inc == MOD_X);
    assign w_at_min = (i_count == '0);

    always_comb begin
        o_cnt_free = i_count;
        o_wrap     = 1'b0;
        if (i_up_dn == DIR_UP) begin
            if (!w_at_max) begin
                o_cnt_free = w_inc[WIDTH-1:0];
            end else if (i_sat == MODE_WRAP) begin
                o_cnt_free = '0;
                o_wrap     = 1'b1;
            end
        end else begin
            if (!w_at_min) begin
                o_cnt_free = i_count - WIDTH'(1);
            end else if (i_sat == MODE_WRAP) begin
                o_cnt_free = LAST[WIDTH-1:0];
                o_wrap     = 1'b1;
            end
        end
    end

    assign o_cnt_run  = w_at_max ? '0 : w_inc[WIDTH-1:0];
    assign o_cnt_load = (w_lv_ext > LAST) ? LAST[WIDTH-1:0] : i_load_val;
    assign o_at_max   = w_at_max;
    assign o_at_min   = w_at_min;

endmodule

// File: rtl/seq_step_counter.sv
// ---------------------------------------------------------------------------
// seq_step_counter
// Modulo-MODULUS step counter with a start/busy/done sequencer.
//   clk    : rising-edge clock
//   aclr_n : asynchronous active-low reset (release synchronised upstream)
//   bus    : seq_step_counter_if.slave control/status bundle
// In IDLE the counter is free-running under sclr > start > load > en.
// A start launches MODULUS busy cycles counting 0..MODULUS-1, followed by a
// single done cycle. sclr aborts any sequence without a done strobe.
// ---------------------------------------------------------------------------
module seq_step_counter
    import seq_ctrl_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int MODULUS = 4
) (
    input  logic                clk,
    input  logic                aclr_n,
    seq_step_counter_if.slave   bus
);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    generate
        if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
            $fatal(1, "seq_step_counter: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_wrap_nxt;
    logic [WIDTH-1:0] w_cnt_free;
    logic             w_wrap;
    logic [WIDTH-1:0] w_cnt_run;
    logic [WIDTH-1:0] w_cnt_load;
    logic             w_at_max;
    logic             w_at_min;

    seq_step_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .i_count    (r_count),
        .i_load_val (bus.load_val),
        .i_up_dn    (bus.up_dn),
        .i_sat      (bus.sat),
        .o_cnt_free (w_cnt_free),
        .o_wrap     (w_wrap),
        .o_cnt_run  (w_cnt_run),
        .o_cnt_load (w_cnt_load),
        .o_at_max   (w_at_max),
        .o_at_min   (w_at_min)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_count;
        w_wrap_nxt  = 1'b0;
        if (bus.sclr) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                    end else if (bus.load) begin
                        w_cnt_nxt = w_cnt_load;
                    end else if (bus.en) begin
                        w_cnt_nxt  = w_cnt_free;
                        w_wrap_nxt = w_wrap;
                    end
                end
                // Return to 0 at the end of a run is not a wrap.
                S_RUN: begin
                    w_cnt_nxt = w_cnt_run;
                    if (w_at_max) w_state_nxt = S_DONE;
                end
                S_DONE: w_state_nxt = S_IDLE;
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_cnt_nxt;
            r_wrap  <= w_wrap_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.count_out  = r_count;
    assign bus.wrap_pulse = r_wrap;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    // In RUN the sequence only ever counts up.
    assign bus.tc = (r_busy || bus.up_dn == DIR_UP) ? w_at_max : w_at_min;

endmodule

// File: tb/tb_seq_step_counter.sv
module tb_seq_step_counter;

    logic clk = 1'b0;
    logic aclr_n = 1'b1;
    always #5 clk = ~clk;

    logic       s_sclr = 0, s_start = 0, s_en = 0, s_up = 0, s_sat = 0, s_load = 0;
    logic [2:0] s_lv = 0;

    seq_step_counter_if #(.WIDTH(2)) if0 ();
    seq_step_counter_if #(.WIDTH(3)) if1 ();

    assign if0.sclr = s_sclr;  assign if1.sclr = s_sclr;
    assign if0.start = s_start; assign if1.start = s_start;
    assign if0.en = s_en;      assign if1.en = s_en;
    assign if0.up_dn = s_up;   assign if1.up_dn = s_up;
    assign if0.sat = s_sat;    assign if1.sat = s_sat;
    assign if0.load = s_load;  assign if1.load = s_load;
    assign if0.load_val = s_lv[1:0];
    assign if1.load_val = s_lv;

    seq_step_counter #(.WIDTH(2), .MODULUS(4)) u0 (.clk(clk), .aclr_n(aclr_n), .bus(if0));
    seq_step_counter #(.WIDTH(3), .MODULUS(5)) u1 (.clk(clk), .aclr_n(aclr_n), .bus(if1));

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: count value, wrap flag, "in sequence" flag, done flag.
    int mod_v [2] = '{4, 5};
    int mc [2] = '{0, 0};
    int mw [2] = '{0, 0};
    int mb [2] = '{0, 0};
    int md [2] = '{0, 0};

    always @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            for (int i = 0; i < 2; i++) begin
                mc[i] <= 0; mw[i] <= 0; mb[i] <= 0; md[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int m, c, lv, nc, nw, nb, nd;
                m  = mod_v[i];
                c  = mc[i];
                lv = (i == 0) ? int'(s_lv) % 4 : int'(s_lv);
                nc = c; nw = 0; nb = mb[i]; nd = 0;
                if (s_sclr) begin
                    nc = 0; nb = 0;
                end else if (mb[i] != 0) begin
                    if (c == m - 1) begin nc = 0; nb = 0; nd = 1; end
                    else nc = c + 1;
                end else if (md[i] != 0) begin
                    nc = c;
                end else if (s_start) begin
                    nc = 0; nb = 1;
                end else if (s_load) begin
                    nc = (lv > m - 1) ? m - 1 : lv;
                end else if (s_en) begin
                    if (s_up) begin
                        if (c < m - 1) nc = c + 1;
                        else if (!s_sat) begin nc = 0; nw = 1; end
                    end else begin
                        if (c > 0) nc = c - 1;
                        else if (!s_sat) begin nc = m - 1; nw = 1; end
                    end
                end
                mc[i] <= nc; mw[i] <= nw; mb[i] <= nb; md[i] <= nd;
            end
        end
    end

    function automatic int exp_tc(input int i);
        if (mb[i] != 0 || s_up) return (mc[i] == mod_v[i] - 1) ? 1 : 0;
        return (mc[i] == 0) ? 1 : 0;
    endfunction

    bit chk_on = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m0.count", 32'(if0.count_out), 32'(mc[0]));
            chk("m0.wrap",  32'(if0.wrap_pulse), 32'(mw[0]));
            chk("m0.busy",  32'(if0.busy), 32'(mb[0]));
            chk("m0.done",  32'(if0.done), 32'(md[0]));
            chk("m0.tc",    32'(if0.tc), 32'(exp_tc(0)));
            chk("m1.count", 32'(if1.count_out), 32'(mc[1]));
            chk("m1.wrap",  32'(if1.wrap_pulse), 32'(mw[1]));
            chk("m1.busy",  32'(if1.busy), 32'(mb[1]));
            chk("m1.done",  32'(if1.done), 32'(md[1]));
            chk("m1.tc",    32'(if1.tc), 32'(exp_tc(1)));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int e1 [6] = '{1, 2, 3, 0, 1, 2};
        int e2 [6] = '{3, 2, 1, 0, 0, 0};

        #1 aclr_n = 1'b0;
        #12 aclr_n = 1'b1;
        chk_on = 1;
        tick();
        chk("reset.count", 32'(if0.count_out), 0);
        chk("reset.busy",  32'(if0.busy), 0);
        chk("reset.done",  32'(if0.done), 0);
        chk("reset.wrap",  32'(if0.wrap_pulse), 0);

        // 1: free up-count with wrap
        s_en = 1; s_up = 1; s_sat = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t1.count", 32'(if0.count_out), 32'(e1[i]));
            chk("t1.wrap",  32'(if0.wrap_pulse), (i == 3) ? 1 : 0);
            chk("t1.tc",    32'(if0.tc), (e1[i] == 3) ? 1 : 0);
        end

        // 2: clamped load, saturating down, then wrap down (MODULUS=5)
        s_en = 0; s_sclr = 1; tick(); s_sclr = 0;
        s_load = 1; s_lv = 3'd7; tick(); s_load = 0;
        chk("t2.load_clamp", 32'(if1.count_out), 4);
        chk("t2.load_full",  32'(if0.count_out), 3);
        s_en = 1; s_up = 0; s_sat = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t2.count", 32'(if1.count_out), 32'(e2[i]));
            chk("t2.wrap",  32'(if1.wrap_pulse), 0);
        end
        s_sat = 0; tick();
        chk("t2.wrap_cnt", 32'(if1.count_out), 4);
        chk("t2.wrap_pls", 32'(if1.wrap_pulse), 1);

        // 3: sequence, second start ignored while busy
        s_en = 0; s_sclr = 1; tick(); s_sclr = 0;
        s_start = 1; tick(); s_start = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t3.busy",  32'(if0.busy), 1);
            chk("t3.count", 32'(if0.count_out), 32'(i));
            chk("t3.done",  32'(if0.done), 0);
            chk("t3.wrap",  32'(if0.wrap_pulse), 0);
            s_start = (i == 1);
            tick();
        end
        s_start = 0;
        chk("t3.done_hi", 32'(if0.done), 1);
        chk("t3.busy_lo", 32'(if0.busy), 0);
        tick();
        chk("t3.done_1cyc", 32'(if0.done), 0);
        for (int i = 0; i < 3; i++) tick();

        // 4: sclr abort in 2nd busy cycle
        s_start = 1; tick(); s_start = 0;
        tick();
        chk("t4.busy2_cnt", 32'(if0.count_out), 1);
        s_sclr = 1; tick(); s_sclr = 0;
        chk("t4.count", 32'(if0.count_out), 0);
        chk("t4.busy",  32'(if0.busy), 0);
        chk("t4.done",  32'(if0.done), 0);
        tick();
        chk("t4.nodone", 32'(if0.done), 0);

        // 5: async reset mid-run, then start+load together
        s_start = 1; tick(); s_start = 0;
        tick(); tick();
        #2 aclr_n = 1'b0;
        #1;
        chk("t5.async_cnt",  32'(if0.count_out), 0);
        chk("t5.async_busy", 32'(if0.busy), 0);
        #8 aclr_n = 1'b1;
        tick();
        s_start = 1; s_load = 1; s_lv = 3'd2; tick(); s_start = 0; s_load = 0;
        chk("t5.start_cnt",  32'(if0.count_out), 0);
        chk("t5.start_busy", 32'(if0.busy), 1);
        for (int i = 0; i < 7; i++) tick();

        // 6: full-range down wrap, then hold
        s_sclr = 1; tick(); s_sclr = 0;
        s_en = 1; s_up = 0; s_sat = 0; tick();
        chk("t6.count", 32'(if0.count_out), 3);
        chk("t6.wrap",  32'(if0.wrap_pulse), 1);
        s_en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6.hold", 32'(if0.count_out), 3);
        end

        // random phase
        for (int n = 0; n < 800; n++) begin
            s_sclr  = ($urandom_range(0, 19) == 0);
            s_start = ($urandom_range(0, 9) == 0);
            s_load  = ($urandom_range(0, 7) == 0);
            s_en    = ($urandom_range(0, 3) != 0);
            s_up    = 1'($urandom_range(0, 1));
            s_sat   = 1'($urandom_range(0, 1));
            s_lv    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) begin
                #2 aclr_n = 1'b0;
                #1 aclr_n = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_step_counter.md
Name: seq_step_counter

Overview:
Parametrised, modulo-N step counter that replaces the fixed 2-bit free-running step counter used to sequence partial-product steps in the sequential multiplier datapath.
- Adds enable, synchronous clear, parallel load, up/down direction and wrap/saturate mode.
- Adds a start/busy/done sequencing FSM, so the multiplier controller can launch an N-step operation with one pulse and receive a completion strobe.

Parameters:
WIDTH, 2, counter width in bits; legal range 1..16.
MODULUS, 4, count range 0..MODULUS-1; legal range 2..2^WIDTH (checked by elaboration-time assertion).

Ports:
clk  input  1  rising-edge clock
aclr_n  input  1  reset aclr_n, asynchronous, active-low; clock clk
sclr  input  1  synchronous clear; highest synchronous priority
start  input  1  launch one N-step sequence; honoured only in IDLE
en  input  1  count enable in IDLE (free mode)
up_dn  input  1  1 = count up, 0 = count down (free mode only)
sat  input  1  1 = saturate at end value, 0 = wrap (free mode only)
load  input  1  parallel load in IDLE
load_val  input  WIDTH  value for load
count_out  output  WIDTH  current count (registered)
tc  output  1  terminal count: combinational decode, count_out at the end value for the current direction (MODULUS-1 when up, 0 when down; in RUN, always MODULUS-1)
wrap_pulse  output  1  registered; high for 1 cycle after any wrap transition
busy  output  1  registered; high while FSM is in RUN
done  output  1  registered; 1-cycle strobe, high exactly while FSM is in DONE

Behaviour:
- Reset (aclr_n low, async): count_out=0, wrap_pulse=0, busy=0, done=0, FSM=IDLE. Deassertion is synchronised externally; the block does not re-synchronise it.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start (with sclr=0). That same edge forces count_out=0.
  - RUN: count_out increments every cycle; en, up_dn, sat and load are ignored. When count_out==MODULUS-1, the next edge sets count_out=0 and moves to DONE. This is an end-of-sequence return, not a wrap: wrap_pulse stays 0.
  - DONE -> IDLE unconditionally after 1 cycle. start is ignored in DONE.
  - Latency: start sampled at edge k; busy is high for cycles k+1..k+MODULUS; done is high in cycle k+MODULUS+1; count_out shows 0,1,..,MODULUS-1 during busy.
- Synchronous priority in IDLE: sclr > start > load > en.
  - sclr: count_out=0, wrap_pulse=0.
  - load: count_out = load_val if load_val <= MODULUS-1, else MODULUS-1 (clamp).
  - en: count by one in the direction given by up_dn.
- Free-mode boundaries:
  - Up at MODULUS-1 with sat=0: goes to 0, wrap_pulse=1 next cycle.
  - Up at MODULUS-1 with sat=1: holds, no pulse.
  - Down at 0 with sat=0: goes to MODULUS-1, wrap_pulse=1.
  - Down at 0 with sat=1: holds.
  - en=0: hold.
- sclr in RUN or DONE: abort to IDLE, count_out=0, busy=0, done=0; no done strobe is issued.
- start and load together in IDLE: start wins; load is dropped.
- Async reset mid-RUN: immediate return to reset values; no done strobe.
- Arithmetic:
  - Next-count logic is computed at WIDTH+1 bits, then compared against MODULUS.
  - When MODULUS==2^WIDTH, the wrap compare must still hit at all-ones; there must be no reliance on natural overflow.

Decomposition:
- Shared package seq_ctrl_pkg holds:
  - FSM state enum (IDLE, RUN, DONE; 2-bit encoding);
  - direction constants DIR_UP=1, DIR_DN=0;
  - mode constants MODE_WRAP=0, MODE_SAT=1.
- One sub-module, seq_step_next: purely combinational next-count and wrap-detect logic, parametrised by WIDTH and MODULUS.
- The top module holds the FSM and all registers.

Test Plan:
1. WIDTH=2, MODULUS=4: reset, then en=1, up_dn=1, sat=0 for 6 cycles -> count 1,2,3,0,1,2; wrap_pulse high only in the cycle after 3->0; tc high when count=3.
2. WIDTH=3, MODULUS=5: load load_val=7 -> count 4 (clamped). Then down with sat=1 for 6 cycles -> 3,2,1,0,0,0; no wrap_pulse. Then sat=0, one more down step -> 4, with wrap_pulse.
3. WIDTH=2, MODULUS=4: start pulse at edge k -> busy cycles k+1..k+4 with count 0,1,2,3; done=1 in cycle k+5 only; wrap_pulse never high. Second start during busy -> ignored.
4. MODULUS=4: start, then sclr at the 2nd busy cycle -> next cycle count=0, busy=0; done never asserted.
5. aclr_n pulsed low mid-RUN at a non-clock time -> outputs at 0 immediately. After release, start and load asserted together -> start wins, count=0, busy=1.
6. WIDTH=2, MODULUS=4 (full range): en=1, up_dn=0 from 0 -> 3 with wrap_pulse. Then en=0 for 3 cycles -> count holds at 3.
